// File: rtl/onchip_mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : onchip_mem_arb_pkg                                        |
// | Description : Shared widths, depth, read-owner encoding and the         |
// |               registered RAM command type for the on-chip RAM arbiter.  |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
package onchip_mem_arb_pkg;

  localparam int AW        = 14;
  localparam int DW        = 16;
  localparam int BEW       = DW / 8;
  localparam int MEM_DEPTH = 13000;

  // Which master a read in flight belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LED  = 2'd2
  } owner_t;

  // One RAM command as presented on the slave side.
  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [BEW-1:0] be;
    logic [DW-1:0]  wdata;
    logic           wr;
    logic           cs;
  } mem_cmd_t;

endpackage : onchip_mem_arb_pkg
`default_nettype wire

// File: rtl/onchip_mem_rd_tracker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : onchip_mem_rd_tracker                                     |
// | Description : Two-stage owner pipeline for reads in flight. Steers the  |
// |               RAM read data to the owning master two cycles after the   |
// |               read was accepted; out-of-range reads return zero.        |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
// | Ports                                                                   |
// |   clk, reset_n          clock, asynchronous active-low reset            |
// |   push_own_i            owner of the command accepted this cycle        |
// |   push_zero_i           accepted read is out of range (zero-fill)       |
// |   mem_readdata_i        RAM read data (one cycle after address)         |
// |   cpu_readdata_o/_valid_o, led_readdata_o/_valid_o   return ports       |
// +------------------------------------------------------------------------+
module onchip_mem_rd_tracker
  import onchip_mem_arb_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  owner_t        push_own_i,
  input  logic          push_zero_i,
  input  logic [DW-1:0] mem_readdata_i,
  output logic [DW-1:0] cpu_readdata_o,
  output logic          cpu_readdatavalid_o,
  output logic [DW-1:0] led_readdata_o,
  output logic          led_readdatavalid_o
);

  owner_t        own1_q, own2_q;
  logic          zero1_q, zero2_q;
  logic [DW-1:0] cpu_hold_q, led_hold_q;
  logic [DW-1:0] rdata;

  // Stage 1 lines up with the command on mem_*, stage 2 with mem_readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own1_q     <= OWN_NONE;
      own2_q     <= OWN_NONE;
      zero1_q    <= 1'b0;
      zero2_q    <= 1'b0;
      cpu_hold_q <= '0;
      led_hold_q <= '0;
    end else begin
      own1_q  <= push_own_i;
      zero1_q <= push_zero_i;
      own2_q  <= own1_q;
      zero2_q <= zero1_q;
      if (cpu_readdatavalid_o) cpu_hold_q <= rdata;
      if (led_readdatavalid_o) led_hold_q <= rdata;
    end
  end

  // Out-of-range reads never reached the RAM, so its output is stale.
  assign rdata               = zero2_q ? '0 : mem_readdata_i;
  assign cpu_readdatavalid_o = (own2_q == OWN_CPU);
  assign led_readdatavalid_o = (own2_q == OWN_LED);
  // Each port shows the last data it received while its valid is low.
  assign cpu_readdata_o      = cpu_readdatavalid_o ? rdata : cpu_hold_q;
  assign led_readdata_o      = led_readdatavalid_o ? rdata : led_hold_q;

endmodule : onchip_mem_rd_tracker
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : onchip_mem_arbiter                                        |
// | Description : Shares one single-port on-chip RAM between the CPU data   |
// |               master (read/write) and the LED refresh reader (read).    |
// |               LED has priority; the CPU is forced through after         |
// |               MAX_CPU_WAIT consecutive refusals. One command per cycle, |
// |               registered onto mem_*; reads return after two cycles.     |
// | Build macro : ONCHIP_ARB_ROUND_ROBIN_EN - replaces the priority and     |
// |               starvation counter with alternating grant on contention.  |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
// | Ports                                                                   |
// |   clk, reset_n                      clock, async active-low reset       |
// |   cpu_* (address/byteenable/read/write/writedata -> waitrequest,        |
// |          readdata, readdatavalid)   CPU Avalon-style master side        |
// |   led_* (address/read -> waitrequest, readdata, readdatavalid)          |
// |   mem_* (address/byteenable/chipselect/write/writedata, readdata)       |
// |   addr_err                          pulse one cycle after an            |
// |                                     out-of-range accept                 |
// +------------------------------------------------------------------------+
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int MEM_DEPTH    = 13000,
  parameter int MAX_CPU_WAIT = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [AW-1:0]  cpu_address,
  input  logic [BEW-1:0] cpu_byteenable,
  input  logic           cpu_read,
  input  logic           cpu_write,
  input  logic [DW-1:0]  cpu_writedata,
  output logic           cpu_waitrequest,
  output logic [DW-1:0]  cpu_readdata,
  output logic           cpu_readdatavalid,
  input  logic [AW-1:0]  led_address,
  input  logic           led_read,
  output logic           led_waitrequest,
  output logic [DW-1:0]  led_readdata,
  output logic           led_readdatavalid,
  output logic [AW-1:0]  mem_address,
  output logic [BEW-1:0] mem_byteenable,
  output logic           mem_chipselect,
  output logic           mem_write,
  output logic [DW-1:0]  mem_writedata,
  input  logic [DW-1:0]  mem_readdata,
  output logic           addr_err
);

  localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(MEM_DEPTH);

  logic cpu_req, led_req, cpu_gnt, led_gnt;

  // Gating with reset_n keeps both waitrequests high during reset.
  assign cpu_req = reset_n & (cpu_read | cpu_write);
  assign led_req = reset_n & led_read;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  // High when the CPU was the most recent winner.
  logic last_cpu_q, last_cpu_d;

  always_comb begin
    cpu_gnt    = cpu_req & (~led_req | ~last_cpu_q);
    led_gnt    = led_req & ~cpu_gnt;
    last_cpu_d = last_cpu_q;
    if (cpu_gnt)      last_cpu_d = 1'b1;
    else if (led_gnt) last_cpu_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_cpu_q <= 1'b1;
    else          last_cpu_q <= last_cpu_d;
  end
`else
  localparam int            SW         = $clog2(MAX_CPU_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_CPU_WAIT);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    cpu_gnt  = cpu_req & (~led_req | (starve_q == STARVE_MAX));
    led_gnt  = led_req & ~cpu_gnt;
    starve_d = starve_q;
    if (!cpu_req || cpu_gnt)      starve_d = '0;
    else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`endif

  assign cpu_waitrequest = ~cpu_gnt;
  assign led_waitrequest = ~led_gnt;

  logic     cpu_inr, led_inr;
  mem_cmd_t cmd_d, cmd_q;
  logic     err_d, err_q;
  owner_t   own_d;
  logic     zero_d;

  assign cpu_inr = ({1'b0, cpu_address} < ADDR_LIMIT);
  assign led_inr = ({1'b0, led_address} < ADDR_LIMIT);

  // An out-of-range accept is still a normal handshake; it just never
  // selects the RAM. A simultaneous read+write is treated as a write.
  always_comb begin
    cmd_d  = '0;
    err_d  = 1'b0;
    own_d  = OWN_NONE;
    zero_d = 1'b0;
    if (cpu_gnt) begin
      cmd_d.addr  = cpu_address;
      cmd_d.be    = cpu_byteenable;
      cmd_d.wdata = cpu_writedata;
      cmd_d.wr    = cpu_write & cpu_inr;
      cmd_d.cs    = cpu_inr;
      err_d       = ~cpu_inr;
      if (!cpu_write) begin
        own_d  = OWN_CPU;
        zero_d = ~cpu_inr;
      end
    end else if (led_gnt) begin
      cmd_d.addr = led_address;
      cmd_d.be   = '1;
      cmd_d.cs   = led_inr;
      err_d      = ~led_inr;
      own_d      = OWN_LED;
      zero_d     = ~led_inr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      err_q <= err_d;
    end
  end

  assign mem_address    = cmd_q.addr;
  assign mem_byteenable = cmd_q.be;
  assign mem_writedata  = cmd_q.wdata;
  assign mem_write      = cmd_q.wr;
  assign mem_chipselect = cmd_q.cs;
  assign addr_err       = err_q;

  onchip_mem_rd_tracker u_rd_tracker (
    .clk                 (clk),
    .reset_n             (reset_n),
    .push_own_i          (own_d),
    .push_zero_i         (zero_d),
    .mem_readdata_i      (mem_readdata),
    .cpu_readdata_o      (cpu_readdata),
    .cpu_readdatavalid_o (cpu_readdatavalid),
    .led_readdata_o      (led_readdata),
    .led_readdatavalid_o (led_readdatavalid)
  );

  // The CPU master must never raise read and write together.
  a_cpu_rd_wr_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n) !(cpu_read && cpu_write)
  );

endmodule : onchip_mem_arbiter
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_onchip_mem_arbiter                                     |
// | Description : Self-checking bench for onchip_mem_arbiter with a RAM     |
// |               slave model, a reference memory image, and a per-cycle    |
// |               monitor for issue, arbitration and read return.           |
// | Build macro : ONCHIP_ARB_ROUND_ROBIN_EN selects alternation checks.     |
// | Revision    : 1.0 - initial release                                     |
// +------------------------------------------------------------------------+
module tb_onchip_mem_arbiter;

  localparam int DEPTH = 13000;
  localparam int MAXW  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] cpu_address = '0;
  logic [1:0]  cpu_byteenable = '0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [15:0] cpu_writedata = '0;
  logic        cpu_waitrequest, cpu_readdatavalid;
  logic [15:0] cpu_readdata;
  logic [13:0] led_address = '0;
  logic        led_read = 1'b0;
  logic        led_waitrequest, led_readdatavalid;
  logic [15:0] led_readdata;
  logic [13:0] mem_address;
  logic [1:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, addr_err;
  logic [15:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.MEM_DEPTH(DEPTH), .MAX_CPU_WAIT(MAXW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .led_address(led_address), .led_read(led_read),
    .led_waitrequest(led_waitrequest), .led_readdata(led_readdata),
    .led_readdatavalid(led_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .addr_err(addr_err)
  );

  // RAM slave: synchronous, read data one cycle after the address.
  logic [15:0] ram [0:DEPTH-1];
  logic [15:0] ram_rd;
  logic        preloaded = 1'b0;

  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 16'(i);
      preloaded <= 1'b1;
    end else if (mem_chipselect && int'(mem_address) < DEPTH) begin
      if (mem_write) begin
        if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
        if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
      end else begin
        ram_rd <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_rd;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  typedef struct { int cyc; logic [15:0] data; } exp_t;
  exp_t        cpu_q[$];
  exp_t        led_q[$];
  logic [15:0] ref_mem [0:DEPTH-1];
  int          cyc = 0;
  int          refused = 0;
  logic        last_cpu = 1'b1;
  logic [15:0] cpu_last = '0, led_last = '0;
  logic        p_acc = 1'b0, p_inr = 1'b0, p_wr = 1'b0;
  logic [13:0] p_addr = '0;
  logic [1:0]  p_be = '0;
  logic [15:0] p_wd = '0;

  initial begin
    logic creq, lreq, cacc, lacc, due;
    logic [15:0] tmp;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        check("rst_mem", {mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata}, 0);
        check("rst_valid", {cpu_readdatavalid, led_readdatavalid, addr_err}, 0);
        check("rst_rdata", {cpu_readdata, led_readdata}, 0);
        check("rst_wait", {cpu_waitrequest, led_waitrequest}, 2'b11);
        cpu_q.delete(); led_q.delete();
        p_acc = 1'b0; refused = 0; last_cpu = 1'b1; cpu_last = '0; led_last = '0;
      end else begin
        // command accepted last cycle must be on mem_* now
        check("mem_cs", mem_chipselect, p_acc && p_inr);
        check("mem_write", mem_write, p_acc && p_inr && p_wr);
        check("addr_err", addr_err, p_acc && !p_inr);
        if (p_acc) check("mem_addr", mem_address, p_addr);
        if (p_acc && p_inr) check("mem_be", mem_byteenable, p_be);
        if (p_acc && p_inr && p_wr) check("mem_wdata", mem_writedata, p_wd);

        due = (cpu_q.size() > 0) && (cpu_q[0].cyc == cyc);
        check("cpu_rdv", cpu_readdatavalid, due);
        if (due) begin
          check("cpu_rdata", cpu_readdata, cpu_q[0].data);
          cpu_last = cpu_q[0].data;
          void'(cpu_q.pop_front());
        end else check("cpu_hold", cpu_readdata, cpu_last);

        due = (led_q.size() > 0) && (led_q[0].cyc == cyc);
        check("led_rdv", led_readdatavalid, due);
        if (due) begin
          check("led_rdata", led_readdata, led_q[0].data);
          led_last = led_q[0].data;
          void'(led_q.pop_front());
        end else check("led_hold", led_readdata, led_last);

        creq = cpu_read || cpu_write;
        lreq = led_read;
        cacc = creq && !cpu_waitrequest;
        lacc = lreq && !led_waitrequest;
        check("one_cmd", cacc && lacc, 0);
        if (creq || lreq) check("accept_any", cacc || lacc, 1);
        if (creq && lreq) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
          check("rr_winner", cacc, !last_cpu);
`else
          check("prio_winner", cacc, refused >= MAXW);
`endif
        end
        if (cacc) last_cpu = 1'b1;
        else if (lacc) last_cpu = 1'b0;
        if (creq && !cacc) refused++;
        else refused = 0;

        p_acc = cacc || lacc;
        if (cacc) begin
          p_addr = cpu_address; p_inr = int'(cpu_address) < DEPTH;
          p_wr = cpu_write; p_be = cpu_byteenable; p_wd = cpu_writedata;
          if (cpu_write) begin
            if (p_inr) begin
              tmp = ref_mem[cpu_address];
              if (cpu_byteenable[0]) tmp[7:0]  = cpu_writedata[7:0];
              if (cpu_byteenable[1]) tmp[15:8] = cpu_writedata[15:8];
              ref_mem[cpu_address] = tmp;
            end
          end else cpu_q.push_back('{cyc + 2, p_inr ? ref_mem[cpu_address] : 16'h0000});
        end else if (lacc) begin
          p_addr = led_address; p_inr = int'(led_address) < DEPTH;
          p_wr = 1'b0; p_be = 2'b11; p_wd = '0;
          led_q.push_back('{cyc + 2, p_inr ? ref_mem[led_address] : 16'h0000});
        end
      end
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic cpu_op(input logic rd, input logic wr, input logic [13:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
    logic ok = 1'b0;
    cpu_address = a; cpu_byteenable = be; cpu_writedata = wd;
    cpu_read = rd; cpu_write = wr;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = !cpu_waitrequest;
    end
    if (!ok) check("cpu_accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic led_op(input logic [13:0] a);
    logic ok = 1'b0;
    led_address = a; led_read = 1'b1;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = !led_waitrequest;
    end
    if (!ok) check("led_accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic cpu_idle();
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic wait_cpu(input string tag, input logic [15:0] exp);
    logic ok = 1'b0;
    for (int t = 0; t < 6 && !ok; t++) begin
      @(negedge clk);
      if (cpu_readdatavalid) begin
        ok = 1'b1;
        check(tag, cpu_readdata, exp);
      end
    end
    if (!ok) check("cpu_return_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [13:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return 14'd12999;
      1:       return 14'd13000;
      2:       return 14'd16383;
      3:       return 14'($urandom_range(0, 16383));
      default: return 14'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic cpu_rand();
    for (int n = 0; n < 120; n++) begin
      cpu_idle();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 1) == 1)
        cpu_op(1'b0, 1'b1, pick_addr(), 2'($urandom_range(0, 3)), 16'($urandom));
      else
        cpu_op(1'b1, 1'b0, pick_addr(), 2'b11, 16'h0);
    end
    cpu_idle();
  endtask

  task automatic led_rand();
    for (int n = 0; n < 120; n++) begin
      led_read = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      led_op(pick_addr());
    end
    led_read = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic exp_cpu;
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // LED read in flight when reset hits must never return
    led_address = 14'd5; led_read = 1'b1;
    @(negedge clk); check("rst_led_accept", led_waitrequest, 0);
    @(posedge clk); #1 led_read = 1'b0; reset_n = 1'b0;
    repeat (3) @(posedge clk); #1 reset_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // CPU write/read, back-to-back, then byte lane merge
    cpu_op(1'b0, 1'b1, 14'd100, 2'b11, 16'hBEEF);
    cpu_op(1'b1, 1'b0, 14'd100, 2'b11, 16'h0);
    cpu_idle(); wait_cpu("cpu_rd_beef", 16'hBEEF);
    cpu_op(1'b0, 1'b1, 14'd100, 2'b10, 16'h12AA);
    cpu_op(1'b1, 1'b0, 14'd100, 2'b11, 16'h0);
    cpu_idle(); wait_cpu("cpu_rd_lane", 16'h12EF);

    // LED back-to-back reads of 0..3
    for (int i = 0; i < 4; i++) begin
      led_address = 14'(i); led_read = 1'b1;
      @(negedge clk); check("led_pipe_accept", led_waitrequest, 0);
      @(posedge clk); #1;
    end
    led_read = 1'b0;
    repeat (4) @(posedge clk); #1;

    // out-of-range and last-word boundary
    cpu_op(1'b0, 1'b1, 14'd13000, 2'b11, 16'hFFFF);
    cpu_idle();
    @(negedge clk);
    check("oor_wr_cs", mem_chipselect, 0);
    check("oor_wr_err", addr_err, 1);
    @(posedge clk); #1;
    cpu_op(1'b1, 1'b0, 14'd13000, 2'b11, 16'h0); cpu_idle(); wait_cpu("oor_rd_13000", 16'h0000);
    cpu_op(1'b1, 1'b0, 14'd16383, 2'b11, 16'h0); cpu_idle(); wait_cpu("oor_rd_16383", 16'h0000);
    cpu_op(1'b1, 1'b0, 14'd12999, 2'b11, 16'h0); cpu_idle(); wait_cpu("rd_12999", 16'h32C7);

    // interleaved owners on consecutive cycles
    cpu_address = 14'd7; cpu_read = 1'b1;
    @(posedge clk); #1 cpu_read = 1'b0; led_address = 14'd8; led_read = 1'b1;
    @(posedge clk); #1 led_read = 1'b0;
    @(negedge clk);
    check("il_cpu_valid", cpu_readdatavalid, 1);
    check("il_cpu_data", cpu_readdata, 16'd7);
    check("il_led_early", led_readdatavalid, 0);
    @(negedge clk);
    check("il_led_valid", led_readdatavalid, 1);
    check("il_led_data", led_readdata, 16'd8);
    @(posedge clk); #1;

    // contention: CPU won last, then both request for 20 cycles
    cpu_op(1'b1, 1'b0, 14'd20, 2'b11, 16'h0);
    led_address = 14'd30; led_read = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
      exp_cpu = (k % 2) == 1;
`else
      exp_cpu = (k % 9) == 8;
`endif
      check("contend_cpu_win", !cpu_waitrequest, exp_cpu);
      @(posedge clk); #1;
    end
    cpu_idle(); led_read = 1'b0;
    repeat (4) @(posedge clk); #1;

    // randomized concurrent traffic
    fork
      cpu_rand();
      led_rand();
    join
    repeat (6) @(posedge clk); #1;
    check("cpu_q_drained", cpu_q.size(), 0);
    check("led_q_drained", led_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so a stuck handshake can never hang the run.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule : tb_onchip_mem_arbiter
`default_nettype wire
